// File: rtl/mem_access_unit.sv
// Multi-cycle memory access stage: valid/ready op intake, SB_DEPTH store buffer, memory port FSM, UART.
// Define MEM_ACCESS_HC_EN to map a free-running cycle counter at HC_ADDR.
module mem_access_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned SB_DEPTH  = 4,
    parameter logic [31:0] UART_ADDR = 32'hf6fff070,
    parameter logic [31:0] HC_ADDR   = 32'hffffff00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic              in_unsigned,
    input  logic [1:0]        in_width,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_data,
    output logic              out_misaligned,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [7:0]        uart,
    output logic              uart_we,
    output logic              sb_empty
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(NB - 1);
    localparam logic [XLEN-1:0] UART_A     = XLEN'(UART_ADDR);
    localparam logic [XLEN-1:0] UART_LINE  = UART_A & ALIGN_MASK;
    localparam logic [OW-1:0]   UART_OFF   = UART_A[OW-1:0];

    typedef enum logic [1:0] {IDLE, LD_REQ, LD_RESP, ST_REQ} state_t;
    state_t state, state_n;

    logic [XLEN-1:0]     sb_addr [SB_DEPTH];
    logic [NB-1:0]       sb_be   [SB_DEPTH];
    logic [XLEN-1:0]     sb_data [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PW:0]         sb_cnt, cnt_n;

    logic            ld_busy, ld_wait, ld_uns;
    logic [XLEN-1:0] ld_line;
    logic [OW-1:0]   ld_off;
    logic [1:0]      ld_width;
    logic [4:0]      ld_rd;

    logic            is_ld, is_st, misal, hc_hit, acc, ld_go, st_go;
    logic [OW-1:0]   off;
    logic [XLEN-1:0] line, wd_in, head_addr, head_data, pl_line, uart_shift;
    logic [3:0]      sm4;
    logic [7:0]      m8;
    logic [NB-1:0]   be_in, head_be;
    logic            head_vld, pl_vld, pl_conf, ld_busy_n;
    logic            req_n, we_n, deq, uart_go, issue, ld_done;
    logic [XLEN-1:0] addr_n, wd_n;
    logic [NB-1:0]   be_n;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] raw, input logic [OW-1:0] o,
                                                input logic [1:0] w, input logic u);
        logic [XLEN-1:0] s, r;
        int unsigned     bits;
        logic            sgn;
        s    = raw >> {o, 3'b000};
        bits = 32'd8 << w;
        if (bits > XLEN) bits = XLEN;
        sgn  = !u && s[bits-1];
        for (int unsigned i = 0; i < XLEN; i++) r[i] = (i < bits) ? s[i] : sgn;
        return r;
    endfunction

    assign is_st = in_is_store;
    assign is_ld = in_is_load && !in_is_store;
    assign off   = in_addr[OW-1:0];
    assign line  = in_addr & ALIGN_MASK;
    assign sm4   = (4'd1 << in_width) - 4'd1;
    assign misal = (is_ld || is_st) &&
                   (((off & sm4[OW-1:0]) != '0) || (in_width == 2'd3 && XLEN == 32));
    assign m8    = 8'((9'd1 << (4'd1 << in_width)) - 9'd1);
    assign be_in = NB'(m8) << off;
    assign wd_in = in_wdata << {off, 3'b000};
    assign acc   = in_valid && in_ready;
    assign ld_go = acc && is_ld && !misal && !hc_hit;
    assign st_go = acc && is_st && !misal;

`ifdef MEM_ACCESS_HC_EN
    localparam logic [XLEN-1:0] HC_A = XLEN'(HC_ADDR);
    logic [XLEN-1:0] hc_val;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hc_val <= '0;
        else      hc_val <= hc_val + XLEN'(1);
    end
    assign hc_hit = is_ld && !misal && in_width[1] && (in_addr == HC_A);
`else
    logic [XLEN-1:0] hc_val;
    assign hc_val = '0;
    assign hc_hit = 1'b0;
`endif

    // An empty buffer lets a store accepted this cycle act as head, so its drain starts next cycle.
    assign head_vld   = (sb_cnt != '0) || st_go;
    assign head_addr  = (sb_cnt != '0) ? sb_addr[rd_ptr] : line;
    assign head_be    = (sb_cnt != '0) ? sb_be[rd_ptr]   : be_in;
    assign head_data  = (sb_cnt != '0) ? sb_data[rd_ptr] : wd_in;
    assign uart_shift = head_data >> {UART_OFF, 3'b000};
    assign pl_vld     = ld_wait || ld_go;
    assign pl_line    = ld_wait ? ld_line : line;

    always_comb begin
        pl_conf = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++)
            if (sb_vld[i] && sb_addr[i] == pl_line) pl_conf = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        req_n   = 1'b0;
        we_n    = mem_we;
        addr_n  = mem_addr;
        be_n    = mem_be;
        wd_n    = mem_wdata;
        deq     = 1'b0;
        uart_go = 1'b0;
        issue   = 1'b0;
        ld_done = 1'b0;
        case (state)
            IDLE: begin
                if (pl_vld && !pl_conf) begin
                    state_n = LD_REQ;
                    req_n   = 1'b1;
                    we_n    = 1'b0;
                    addr_n  = pl_line;
                    be_n    = '1;
                    issue   = 1'b1;
                end else if (head_vld) begin
                    if (head_addr == UART_LINE) begin
                        deq     = 1'b1;
                        uart_go = 1'b1;
                    end else begin
                        state_n = ST_REQ;
                        req_n   = 1'b1;
                        we_n    = 1'b1;
                        addr_n  = head_addr;
                        be_n    = head_be;
                        wd_n    = head_data;
                    end
                end
            end
            LD_REQ: begin
                req_n = !mem_gnt;
                if (mem_gnt) state_n = LD_RESP;
            end
            LD_RESP: begin
                if (mem_rvalid) begin
                    state_n = IDLE;
                    ld_done = 1'b1;
                end
            end
            ST_REQ: begin
                req_n = !mem_gnt;
                if (mem_gnt) begin
                    state_n = IDLE;
                    deq     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cnt_n     = sb_cnt + (PW+1)'(st_go) - (PW+1)'(deq);
    assign ld_busy_n = (ld_busy && !ld_done) || ld_go;

    always_ff @(posedge clk) begin
        if (st_go) begin
            sb_addr[wr_ptr] <= line;
            sb_be[wr_ptr]   <= be_in;
            sb_data[wr_ptr] <= wd_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req <= 1'b0;  mem_we <= 1'b0;  mem_addr <= '0;  mem_be <= '0;  mem_wdata <= '0;
            uart <= '0;  uart_we <= 1'b0;
            sb_vld <= '0;  wr_ptr <= '0;  rd_ptr <= '0;  sb_cnt <= '0;
            in_ready <= 1'b0;  sb_empty <= 1'b0;
            ld_busy <= 1'b0;  ld_wait <= 1'b0;  ld_uns <= 1'b0;  ld_line <= '0;
            ld_off <= '0;  ld_width <= '0;  ld_rd <= '0;
            out_valid <= 1'b0;  out_rd <= '0;  out_data <= '0;  out_misaligned <= 1'b0;
        end else begin
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_be    <= be_n;
            mem_wdata <= wd_n;
            uart_we   <= uart_go;
            if (uart_go) uart <= uart_shift[7:0];
            // Clear follows set so a same-slot enqueue+dequeue leaves the slot empty.
            if (st_go) begin
                sb_vld[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (deq) begin
                sb_vld[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            sb_cnt   <= cnt_n;
            in_ready <= !ld_busy_n && (cnt_n != (PW+1)'(SB_DEPTH));
            sb_empty <= (cnt_n == '0);
            ld_busy  <= ld_busy_n;
            if (ld_go) begin
                ld_wait  <= !issue;
                ld_line  <= line;
                ld_off   <= off;
                ld_width <= in_width;
                ld_uns   <= in_unsigned;
                ld_rd    <= in_rd;
            end else if (issue) begin
                ld_wait <= 1'b0;
            end
            out_valid <= 1'b0;
            if (ld_done) begin
                out_valid      <= 1'b1;
                out_rd         <= ld_rd;
                out_data       <= extract(mem_rdata, ld_off, ld_width, ld_uns);
                out_misaligned <= 1'b0;
            end else if (acc && !ld_go) begin
                out_valid      <= 1'b1;
                out_misaligned <= misal;
                out_rd         <= is_st ? '0 : in_rd;
                if (misal || is_st) out_data <= '0;
                else if (hc_hit)    out_data <= extract(hc_val, off, in_width, in_unsigned);
                else                out_data <= in_addr;
            end
        end
    end
endmodule
